// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared definitions for the bit-serial 3-bit subtractor:
//                operand width and the sequencing state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // Operand / result width of the subtractor.
    localparam int SUB_W = 3;

    // Sequencing states. BITi computes result bit i.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BIT0 = 3'd1,
        BIT1 = 3'd2,
        BIT2 = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage : sub_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : One-bit full adder. Used time-multiplexed by the serial
//                subtractor (a - b - br == a + ~b + ~br, borrow == ~carry).
//  Ports       : a, b, cin  - addend bits and carry-in
//                sum, cout  - sum bit and carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | ((a ^ b) & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/subtractor_3b_seq.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_3b_seq
//  Description : Bit-serial 3-bit subtractor, LSB first, computing
//                a - b - bin modulo 8 one bit per clock, with the per-bit
//                borrow chain exposed. start/busy/done handshake.
//  Ports       : clock, reset        - clock, synchronous active-high reset
//                start, a, b, bin    - request and operands (latched on accept)
//                busy                - high while BIT0..BIT2
//                done                - one-cycle pulse when results are final
//                diff, bout, neg     - difference, borrow chain, final borrow
//  Revision    : 1.0 - initial release
// ============================================================================
module subtractor_3b_seq
    import sub_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SUB_W-1:0] a,
    input  logic [SUB_W-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [SUB_W-1:0] diff,
    output logic [SUB_W-1:0] bout,
    output logic             neg
);

    state_t           r_state;
    state_t           w_state_next;

    logic [SUB_W-1:0] r_a;
    logic [SUB_W-1:0] r_b;
    logic             r_bin;
    logic [SUB_W-1:0] r_diff;
    logic [SUB_W-1:0] r_bout;
    logic             r_neg;

    logic             w_accept;
    logic             w_busy;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_br;
    logic             w_sum;
    logic             w_cout;
    logic [SUB_W-1:0] w_diff_upd;
    logic [SUB_W-1:0] w_bout_upd;

    // start is only honoured between operations.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_busy   = (r_state == BIT0) || (r_state == BIT1) || (r_state == BIT2);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = start ? BIT0 : IDLE;
            BIT0:    w_state_next = BIT1;
            BIT1:    w_state_next = BIT2;
            BIT2:    w_state_next = DONE;
            DONE:    w_state_next = start ? BIT0 : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit selection: the state itself is the bit index. The borrow into
    // bit i is the latched bin for bit 0, else the borrow already stored
    // for bit i-1.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_bit = 1'b0;
        w_b_bit = 1'b0;
        w_br    = 1'b0;
        case (r_state)
            BIT0: begin
                w_a_bit = r_a[0];
                w_b_bit = r_b[0];
                w_br    = r_bin;
            end
            BIT1: begin
                w_a_bit = r_a[1];
                w_b_bit = r_b[1];
                w_br    = r_bout[0];
            end
            BIT2: begin
                w_a_bit = r_a[2];
                w_b_bit = r_b[2];
                w_br    = r_bout[1];
            end
            default: begin
                w_a_bit = 1'b0;
                w_b_bit = 1'b0;
                w_br    = 1'b0;
            end
        endcase
    end

    // Subtraction through the adder: a - b - br == a + ~b + ~br, and the
    // borrow out is the complement of the carry out.
    full_adder u_full_adder (
        .a    (w_a_bit),
        .b    (~w_b_bit),
        .cin  (~w_br),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Result vectors with the current bit slot replaced.
    always_comb begin
        w_diff_upd = r_diff;
        w_bout_upd = r_bout;
        case (r_state)
            BIT0: begin
                w_diff_upd[0] = w_sum;
                w_bout_upd[0] = ~w_cout;
            end
            BIT1: begin
                w_diff_upd[1] = w_sum;
                w_bout_upd[1] = ~w_cout;
            end
            BIT2: begin
                w_diff_upd[2] = w_sum;
                w_bout_upd[2] = ~w_cout;
            end
            default: begin
                w_diff_upd = r_diff;
                w_bout_upd = r_bout;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latches and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_bin  <= 1'b0;
            r_diff <= '0;
            r_bout <= '0;
            r_neg  <= 1'b0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_bin  <= bin;
            r_diff <= '0;
            r_bout <= '0;
            r_neg  <= 1'b0;
        end else if (w_busy) begin
            r_diff <= w_diff_upd;
            r_bout <= w_bout_upd;
            if (r_state == BIT2) begin
                r_neg <= ~w_cout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = w_busy;
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign neg  = r_neg;

endmodule : subtractor_3b_seq
`default_nettype wire

// File: tb/tb_subtractor_3b_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subtractor_3b_seq
//  Description : Self-checking bench for subtractor_3b_seq. Expected
//                results are queued when an operation is started and
//                popped when done is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_subtractor_3b_seq;

    typedef struct packed {
        logic [2:0] diff;
        logic [2:0] bout;
        logic       neg;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] a     = '0;
    logic [2:0] b     = '0;
    logic       bin   = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] diff;
    logic [2:0] bout;
    logic       neg;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    subtractor_3b_seq dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .neg   (neg)
    );

    always #5 clock = ~clock;

    // Reference: borrow out of bit i is set when the low i+1 bits of a are
    // smaller than the low i+1 bits of b plus bin.
    function automatic exp_t model(input int ai, input int bi, input int ci);
        exp_t e;
        e.diff = 3'((ai - bi - ci) & 7);
        for (int i = 0; i < 3; i++) begin
            int m;
            m = (1 << (i + 1)) - 1;
            e.bout[i] = ((ai & m) < ((bi & m) + ci));
        end
        e.neg = (ai < (bi + ci));
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a start for one edge and queue the expected result.
    task automatic launch(input int ai, input int bi, input int ci, input bit hold);
        a     = 3'(ai);
        b     = 3'(bi);
        bin   = ci[0];
        start = 1'b1;
        sb_q.push_back(model(ai, bi, ci));
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Wait (bounded) for done; returns the number of edges waited.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: done seen with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            if ({diff, bout, neg} !== {e.diff, e.bout, e.neg}) begin
                errors++;
                $display("FAIL %s: got diff=%0d bout=%b neg=%b, want diff=%0d bout=%b neg=%b",
                         name, diff, bout, neg, e.diff, e.bout, e.neg);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a = 3'd5; b = 3'd1; bin = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, diff, bout, neg} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%0d bout=%b neg=%b, want all 0",
                     busy, done, diff, bout, neg);
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins_over_start: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int ops[6][3] = '{'{5,3,0}, '{3,5,0}, '{0,0,1}, '{7,7,0}, '{6,1,1}, '{2,7,1}};
        int lat;
        for (int k = 0; k < 6; k++) begin
            launch(ops[k][0], ops[k][1], ops[k][2], 1'b0);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL basic%0d_busy: got %b want 1", k, busy);
            end
            wait_done(lat);
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL basic%0d_latency: got %0d edges after accept want 3", k, lat);
            end
            check_result($sformatf("basic%0d_result", k));
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL basic%0d_idle: got done=%b busy=%b want 0 0", k, done, busy);
            end
            check_held(k);
            tick();
        end
    endtask

    // Results persist in IDLE.
    task automatic check_held(input int k);
        exp_t e;
        int   ai;
        int   bi;
        int   ci;
        ai = int'(a); bi = int'(b); ci = int'(bin);
        e = model(ai, bi, ci);
        checks++;
        if ({diff, bout, neg} !== {e.diff, e.bout, e.neg}) begin
            errors++;
            $display("FAIL basic%0d_hold: got diff=%0d bout=%b neg=%b, want diff=%0d bout=%b neg=%b",
                     k, diff, bout, neg, e.diff, e.bout, e.neg);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int pulses;
        launch(6, 2, 0, 1'b0);
        tick();                       // now in BIT1
        a = 3'd1; b = 3'd6; bin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL ignore_latency: got %0d want 1", lat);
        end
        check_result("ignore_result");
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL ignore_extra_done: got %0d extra pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(4, 6, 1, 1'b1);        // start stays high
        a = 3'd7; b = 3'd2; bin = 1'b1;
        sb_q.push_back(model(7, 2, 1));
        wait_done(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d want 3", lat);
        end
        check_result("b2b_first_result");
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b want 1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d edges want 3 (4 cycles between dones)", lat);
        end
        check_result("b2b_second_result");
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        launch(5, 3, 0, 1'b0);
        tick();                       // BIT1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb_q.pop_back());       // aborted operation
        checks++;
        if ({busy, done, diff, bout, neg} !== 9'b0) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b done=%b diff=%0d bout=%b neg=%b, want all 0",
                     busy, done, diff, bout, neg);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_done: got %0d pulses want 0", pulses);
        end
        launch(1, 4, 1, 1'b0);
        wait_done(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL midreset_fresh_latency: got %0d want 3", lat);
        end
        check_result("midreset_fresh_result");
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_subtractor_3b_seq
`default_nettype wire

// File: doc/subtractor_3b_seq.md
# subtractor_3b_seq

Bit-serial 3-bit subtractor with borrow-in. It computes a − b − bin one bit per clock, LSB first, and exposes the per-bit borrow chain. It is the inverse-direction companion of the 3-bit ripple adder, so the datapath can decrement 3-bit game counters (players, votes, rounds) without a second combinational carry chain. It sits between the game-state registers and the counter-update logic and uses a start/busy/done handshake.

## Interface
- Parameters: none. Width is fixed at 3 bits.
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when idle or in DONE
- a  in  3  minuend; latched on an accepted start
- b  in  3  subtrahend; latched on an accepted start
- bin  in  1  borrow-in; latched on an accepted start
- busy  out  1  high while bits are being computed
- done  out  1  one-cycle pulse when diff, bout and neg are final
- diff  out  3  a − b − bin modulo 8
- bout  out  3  bout[i] is the borrow out of bit i; bout[2] is the final borrow
- neg  out  1  equals bout[2]; high when a < b + bin (unsigned)

## Operation
- States are IDLE, BIT0, BIT1, BIT2, DONE.
- **Start accept:**
  - An accepted start in IDLE or DONE latches a, b and bin.
  - It also clears diff, bout and neg to 0 and moves to BIT0.
  - start is ignored in BIT0, BIT1 and BIT2.
- **Per-bit step (state BITi, i = 0..2):**
  - diff[i] = a[i] ^ b[i] ^ br.
  - bout[i] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br).
  - br is the latched bin for i = 0, otherwise bout[i−1].
- **Transitions:**
  - BIT0 → BIT1 → BIT2 → DONE, one state per cycle.
  - At the end of BIT2, neg is written with the bit-2 borrow.
- **DONE:**
  - DONE lasts one cycle.
  - With start = 1 it goes to BIT0 (back-to-back); otherwise it goes to IDLE.
- **Result hold:** diff, bout and neg hold their values in IDLE until the next accepted start.
- **Outputs decoded from state:**
  - busy = state ∈ {BIT0, BIT1, BIT2}.
  - done = (state == DONE).
- **Arithmetic rule:** every operand combination, including bin = 1 with a = b = 0, is legal. The result wraps modulo 8 and neg flags the wrap.
- **Reset:**
  - Reset in any state, including mid-operation, forces IDLE.
  - It also forces busy = 0, done = 0, diff = 0, bout = 0, neg = 0 and clears the latched operands.
  - If reset and start are high in the same cycle, reset wins.

## Timing
- Start accepted at edge N:
  - busy is high for cycles N+1 through N+3.
  - diff[i] and bout[i] become valid after edge N+1+i.
  - done is high in cycle N+4, and diff, bout and neg are final from then on.
- Latency is 4 cycles from the start edge to done.
- Back-to-back throughput is one result per 4 cycles.
- Partial diff and bout bits are visible while busy = 1. Consumers sample only on done.

## Structure
- A shared package `sub_pkg` holds:
  - the state enum (IDLE, BIT0, BIT1, BIT2, DONE);
  - the constant SUB_W = 3.
- One sub-module: a single time-multiplexed `full_adder` instance, wired as follows.
  - Inputs: a = a_q[i], b = ~b_q[i], cin = ~br.
  - diff[i] is taken from sum; bout[i] = ~cout.
- The bit index is derived from the state. Use no separate counter.

## Test plan
- a=5, b=3, bin=0 → done 4 cycles after start; diff=2, bout=3'b010, neg=0.
- a=3, b=5, bin=0 → diff=6, bout=3'b100, neg=1.
- a=0, b=0, bin=1 → diff=7, bout=3'b111, neg=1. Also a=7, b=7, bin=0 → diff=0, bout=0, neg=0.
- Start pulsed again in BIT1 with different operands → ignored; result equals the first operation; exactly one done pulse.
- Start held high through DONE → second operation begins the next cycle; done pulses are 4 cycles apart; both results correct.
- Reset asserted in BIT1 → next cycle IDLE, all outputs 0, no done. A fresh start afterwards completes correctly.
